tone_freq_selector: RTL and testbench

//  Programmable tone/waveform generator for the lab top level. A reloadable divider turns clk into a tick at a

---
 rtl/tone_pkg.sv | 33 +++
 rtl/tone_freq_selector_sine_quarter_rom.sv | 22 ++
 rtl/tone_freq_selector.sv | 93 +++++++++
 tb/tb_tone_freq_selector.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared widths, waveform-select codes and switch-bank layout for the tone generator.
package tone_pkg;

    localparam int unsigned DIV_W  = 8;
    localparam int unsigned PH_W   = 8;
    localparam int unsigned WAVE_W = 8;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned SW_W   = SEL_W + DIV_W;
    localparam int unsigned ROM_AW = 6;
    localparam int unsigned ROM_DW = 7;

    localparam logic [WAVE_W-1:0] MIDSCALE = 8'h80;
    localparam logic [DIV_W-1:0]  DIV_MAX  = '1;

    typedef enum logic [SEL_W-1:0] {
        WS_SQUARE = 3'b000,
        WS_SAW    = 3'b001,
        WS_TRI    = 3'b010,
        WS_RSAW   = 3'b011,
        WS_SINE   = 3'b100
    } wave_sel_e;

    typedef struct packed {
        wave_sel_e        sel;
        logic [DIV_W-1:0] load;
    } sw_cfg_t;

    // Fold the phase into a quarter-wave ROM address (mirror the second quarter).
    function automatic logic [ROM_AW-1:0] sine_index(input logic [PH_W-1:0] p);
        return p[PH_W-2] ? ~p[ROM_AW-1:0] : p[ROM_AW-1:0];
    endfunction

endpackage

// File: rtl/tone_freq_selector_sine_quarter_rom.sv
// Quarter-wave sine magnitude table: mag = round(127*sin(pi/2*(k+0.5)/64)).
module sine_quarter_rom
    import tone_pkg::*;
(
    input  logic [ROM_AW-1:0] idx_i,
    output logic [ROM_DW-1:0] mag_o_c
);

    localparam logic [ROM_DW-1:0] ROM [64] = '{
        7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
        7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
        7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
        7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
        7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
        7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
        7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
        7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
    };

    assign mag_o_c = ROM[idx_i];

endmodule

// File: rtl/tone_freq_selector.sv
// Switch-programmable tone generator: reloadable divider -> phase counter -> registered waveform shaper.
module tone_freq_selector
    import tone_pkg::*;
(
    output logic              cout4,
    input  logic [SW_W-1:0]   SW,
    input  logic              clk,
    input  logic              init,
    output logic              cout5,
    output logic              cout6,
    output logic              cout7,
    output logic              cout0,
    output logic              cout1,
    output logic              cout2,
    output logic              cout3,
    output logic              FreqSelector,
    output logic [WAVE_W-1:0] wave,
    input  logic              rst
);

    sw_cfg_t             sw_cfg;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic                tick_q, tick_d;
    logic [PH_W-1:0]     cout_q, cout_d;
    logic [WAVE_W-1:0]   wave_q, wave_d;
    logic [WAVE_W-1:0]   tri_v;
    logic [ROM_DW-1:0]   sine_mag;

    assign sw_cfg = sw_cfg_t'(SW);

    // Divider: preload while idle, count up and reload at all-ones so a period is never cut short.
    // The tick is registered so it is high exactly in the cycle the counter sits at all-ones.
    always_comb begin
        div_cnt_d = sw_cfg.load;
        tick_d    = 1'b0;
        if (init) begin
            if (div_cnt_q != DIV_MAX) begin
                div_cnt_d = div_cnt_q + DIV_W'(1);
            end
            tick_d = (div_cnt_d == DIV_MAX);
        end
    end

    // A tick already registered still advances the phase even if init drops in that cycle.
    always_comb begin
        cout_d = cout_q + PH_W'(tick_q);
    end

    sine_quarter_rom u_sine_rom (
        .idx_i   (sine_index(cout_q)),
        .mag_o_c (sine_mag)
    );

    always_comb begin
        tri_v  = {cout_q[PH_W-2:0], 1'b0};
        wave_d = MIDSCALE;
        case (sw_cfg.sel)
            WS_SQUARE: wave_d = cout_q[PH_W-1] ? '1 : '0;
            WS_SAW:    wave_d = cout_q;
            WS_TRI:    wave_d = cout_q[PH_W-1] ? ~tri_v : tri_v;
            WS_RSAW:   wave_d = ~cout_q;
            WS_SINE:   wave_d = cout_q[PH_W-1] ? (MIDSCALE - WAVE_W'(sine_mag))
                                               : (MIDSCALE + WAVE_W'(sine_mag));
            default:   wave_d = MIDSCALE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_q <= '0;
            tick_q    <= 1'b0;
            cout_q    <= '0;
            wave_q    <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            tick_q    <= tick_d;
            cout_q    <= cout_d;
            wave_q    <= wave_d;
        end
    end

    assign FreqSelector = tick_q;
    assign wave         = wave_q;
    assign cout0        = cout_q[0];
    assign cout1        = cout_q[1];
    assign cout2        = cout_q[2];
    assign cout3        = cout_q[3];
    assign cout4        = cout_q[4];
    assign cout5        = cout_q[5];
    assign cout6        = cout_q[6];
    assign cout7        = cout_q[7];

endmodule

// File: tb/tb_tone_freq_selector.sv
// Directed self-checking bench for tone_freq_selector.
module tb_tone_freq_selector;

    logic        clk;
    logic        en;
    logic        rst;
    logic        init;
    logic [10:0] SW;
    logic        cout0, cout1, cout2, cout3, cout4, cout5, cout6, cout7;
    logic        FreqSelector;
    logic [7:0]  wave;
    logic [7:0]  cout;

    int total = 0;
    int bad   = 0;

    assign cout = {cout7, cout6, cout5, cout4, cout3, cout2, cout1, cout0};

    tone_freq_selector dut (
        .cout4        (cout4),
        .SW           (SW),
        .clk          (clk),
        .init         (init),
        .cout5        (cout5),
        .cout6        (cout6),
        .cout7        (cout7),
        .cout0        (cout0),
        .cout1        (cout1),
        .cout2        (cout2),
        .cout3        (cout3),
        .FreqSelector (FreqSelector),
        .wave         (wave),
        .rst          (rst)
    );

    // Enable-gated oscillator, 10 ns period.
    initial clk = 1'b0;
    always begin
        #5;
        if (en) clk = ~clk;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Negedges waited until FreqSelector is seen high; limit+1 if it never comes.
    task automatic wait_tick(input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (FreqSelector !== 1'b1 && n <= limit);
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b0; init = 1'b0; SW = 11'b000_00000000;
        #10;
        total++; if (cout !== 8'h00) begin bad++; $display("FAIL reset_cout: got %h want 00", cout); end
        total++; if (FreqSelector !== 1'b0) begin bad++; $display("FAIL reset_fs: got %b want 0", FreqSelector); end
        total++; if (wave !== 8'h00) begin bad++; $display("FAIL reset_wave: got %h want 00", wave); end
        rst = 1'b1;
        en  = 1'b1;
        repeat (4) @(negedge clk);
        total++; if (cout !== 8'h00 || FreqSelector !== 1'b0 || wave !== 8'h00) begin
            bad++; $display("FAIL idle_outputs: got cout=%h fs=%b wave=%h want 00/0/00", cout, FreqSelector, wave);
        end
    endtask

    task automatic test_saw_rate();
        int n;
        logic [7:0] c;
        SW = 11'b001_00110010;
        @(negedge clk);
        init = 1'b1;
        wait_tick(400, n);
        // The cycle in which init rose is the first cycle of the period.
        total++; if (n + 1 != 206) begin bad++; $display("FAIL first_tick_50: got %0d want 206", n + 1); end
        total++; if (cout !== 8'h00) begin bad++; $display("FAIL cout_at_first_tick: got %h want 00", cout); end
        for (int i = 0; i < 3; i++) begin
            c = cout;
            @(negedge clk);
            total++; if (cout !== 8'(c + 8'd1)) begin bad++; $display("FAIL cout_step: got %h want %h", cout, 8'(c + 8'd1)); end
            total++; if (wave !== c) begin bad++; $display("FAIL saw_wave: got %h want %h", wave, c); end
            total++; if (FreqSelector !== 1'b0) begin bad++; $display("FAIL tick_width: got %b want 0", FreqSelector); end
            wait_tick(400, n);
            total++; if (n + 1 != 206) begin bad++; $display("FAIL period_50: got %0d want 206", n + 1); end
        end
    endtask

    task automatic test_rate_change();
        int n;
        repeat (3) @(negedge clk);
        SW = 11'b001_01100100;
        wait_tick(400, n);
        total++; if (n + 3 != 206) begin bad++; $display("FAIL period_after_change: got %0d want 206", n + 3); end
        wait_tick(400, n);
        total++; if (n != 156) begin bad++; $display("FAIL period_100: got %0d want 156", n); end
        repeat (3) @(negedge clk);
        SW = 11'b001_11001000;
        wait_tick(400, n);
        total++; if (n + 3 != 156) begin bad++; $display("FAIL period_before_200: got %0d want 156", n + 3); end
        wait_tick(400, n);
        total++; if (n != 56) begin bad++; $display("FAIL period_200: got %0d want 56", n); end
    endtask

    task automatic test_square_fast();
        int n;
        logic [7:0] c;
        logic [7:0] exp_w;
        bit wrapped;
        repeat (3) @(negedge clk);
        SW = 11'b000_11111111;
        wait_tick(400, n);
        total++; if (n + 3 != 56) begin bad++; $display("FAIL period_before_ff: got %0d want 56", n + 3); end
        wrapped = 1'b0;
        c = cout;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            exp_w = c[7] ? 8'hFF : 8'h00;
            total++; if (FreqSelector !== 1'b1) begin bad++; $display("FAIL tick_every_clk: got %b want 1", FreqSelector); end
            total++; if (cout !== 8'(c + 8'd1)) begin bad++; $display("FAIL fast_cout: got %h want %h", cout, 8'(c + 8'd1)); end
            total++; if (wave !== exp_w) begin bad++; $display("FAIL square_wave: cout %h got %h want %h", c, wave, exp_w); end
            if (c == 8'hFF && cout == 8'h00) wrapped = 1'b1;
            c = cout;
        end
        total++; if (!wrapped) begin bad++; $display("FAIL cout_wrap: got 0 want 1"); end
    endtask

    task automatic test_sine();
        logic [7:0] c;
        logic [7:0] val [256];
        SW = 11'b100_11111111;
        c = cout;
        for (int i = 0; i < 260; i++) begin
            @(negedge clk);
            val[c] = wave;
            c = cout;
        end
        total++; if (val[0]   !== 8'h82) begin bad++; $display("FAIL sine_0: got %h want 82", val[0]); end
        total++; if (val[32]  !== 8'hDB) begin bad++; $display("FAIL sine_32: got %h want db", val[32]); end
        total++; if (val[64]  !== 8'hFF) begin bad++; $display("FAIL sine_64: got %h want ff", val[64]); end
        total++; if (val[96]  !== 8'hD9) begin bad++; $display("FAIL sine_96: got %h want d9", val[96]); end
        total++; if (val[128] !== 8'h7E) begin bad++; $display("FAIL sine_128: got %h want 7e", val[128]); end
        total++; if (val[160] !== 8'h25) begin bad++; $display("FAIL sine_160: got %h want 25", val[160]); end
        total++; if (val[192] !== 8'h01) begin bad++; $display("FAIL sine_192: got %h want 01", val[192]); end
        total++; if (val[224] !== 8'h27) begin bad++; $display("FAIL sine_224: got %h want 27", val[224]); end
        // Half-wave antisymmetry about midscale.
        for (int p = 0; p < 128; p++) begin
            total++;
            if (9'(val[p]) + 9'(val[p + 128]) !== 9'h100) begin
                bad++; $display("FAIL sine_symmetry: p=%0d got %h+%h want sum 100", p, val[p], val[p + 128]);
            end
        end
    endtask

    task automatic test_hold();
        int n;
        logic [7:0] c0;
        logic [7:0] c1;
        c0 = cout;
        SW = 11'b001_00110010;
        init = 1'b0;
        @(negedge clk);
        c1 = cout;
        total++; if (c1 !== 8'(c0 + 8'd1)) begin bad++; $display("FAIL tick_completes: got %h want %h", c1, 8'(c0 + 8'd1)); end
        total++; if (FreqSelector !== 1'b0) begin bad++; $display("FAIL hold_fs_first: got %b want 0", FreqSelector); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++; if (cout !== c1) begin bad++; $display("FAIL hold_cout: got %h want %h", cout, c1); end
            total++; if (wave !== c1) begin bad++; $display("FAIL hold_wave: got %h want %h", wave, c1); end
            total++; if (FreqSelector !== 1'b0) begin bad++; $display("FAIL hold_fs: got %b want 0", FreqSelector); end
        end
        init = 1'b1;
        wait_tick(400, n);
        total++; if (n + 1 != 206) begin bad++; $display("FAIL resume_period: got %0d want 206", n + 1); end
        total++; if (cout !== c1) begin bad++; $display("FAIL resume_cout_held: got %h want %h", cout, c1); end
        @(negedge clk);
        total++; if (cout !== 8'(c1 + 8'd1)) begin bad++; $display("FAIL resume_cout_step: got %h want %h", cout, 8'(c1 + 8'd1)); end
    endtask

    task automatic test_reset_mid();
        int n;
        repeat (50) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        total++; if (cout !== 8'h00) begin bad++; $display("FAIL async_rst_cout: got %h want 00", cout); end
        total++; if (FreqSelector !== 1'b0) begin bad++; $display("FAIL async_rst_fs: got %b want 0", FreqSelector); end
        total++; if (wave !== 8'h00) begin bad++; $display("FAIL async_rst_wave: got %h want 00", wave); end
        @(negedge clk);
        rst = 1'b1;
        wait_tick(400, n);
        total++; if (n + 1 != 256) begin bad++; $display("FAIL first_tick_after_rst: got %0d want 256", n + 1); end
        total++; if (cout !== 8'h00) begin bad++; $display("FAIL cout_after_rst: got %h want 00", cout); end
        wait_tick(400, n);
        total++; if (n != 206) begin bad++; $display("FAIL period_after_rst: got %0d want 206", n); end
        total++; if (cout !== 8'h01) begin bad++; $display("FAIL cout_second_tick: got %h want 01", cout); end
    endtask

    initial begin
        test_reset();
        test_saw_rate();
        test_rate_change();
        test_square_fast();
        test_sine();
        test_hold();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
